// File: rtl/lsu_mem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem
// Purpose  : Load/store unit front end. Accepts one memory op at a time
//            from EX, classifies it (mode legality, alignment, address
//            range), presents a single-cycle access to the data cache and
//            returns load writeback, store completion or an exception.
//            Optional feature: define MISALIGN_TRAP_EN to trap misaligned
//            H/HU/W accesses; left undefined, unaligned accesses proceed.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem #(
    parameter int          XLEN      = 32,
    parameter int unsigned DMEM_BASE = 32'h10000,
    parameter int unsigned DMEM_SIZE = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic [2:0]      req_mode,
    input  logic [XLEN-1:0] req_base,
    input  logic [XLEN-1:0] req_imm,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic [XLEN-1:0] dc_addr,
    output logic [XLEN-1:0] dc_wdata,
    output logic [2:0]      dc_mode,
    output logic            dc_write_en,
    output logic            dc_read_en,
    input  logic [XLEN-1:0] dc_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            st_done,
    output logic            exc_valid,
    output logic [1:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr
);

    // Memory mode encoding shared with the decoder (funct3 style).
    localparam logic [2:0] c_mode_b  = 3'b000;
    localparam logic [2:0] c_mode_h  = 3'b001;
    localparam logic [2:0] c_mode_w  = 3'b010;
    localparam logic [2:0] c_mode_bu = 3'b100;
    localparam logic [2:0] c_mode_hu = 3'b101;

    // Exception causes.
    localparam logic [1:0] c_cause_mode = 2'b00;
    localparam logic [1:0] c_cause_mald = 2'b01;
    localparam logic [1:0] c_cause_mast = 2'b10;
    localparam logic [1:0] c_cause_oor  = 2'b11;

    // Range bounds carried one bit wider so ea+size-1 cannot wrap.
    localparam logic [XLEN:0] c_lo = (XLEN+1)'(DMEM_BASE);
    localparam logic [XLEN:0] c_hi = (XLEN+1)'(DMEM_BASE) + (XLEN+1)'(DMEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [XLEN-1:0] r_ea;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_mode;
    logic [4:0]      r_rd;
    logic            r_load;
    logic [1:0]      r_cause;

    logic [XLEN-1:0] w_ea;
    logic [XLEN:0]   w_ea_ext;
    logic [XLEN:0]   w_last;
    logic [1:0]      w_span;
    logic            w_mode_ok;
    logic            w_misalign;
    logic            w_oor;
    logic            w_fault;
    logic [1:0]      w_cause;
    logic            w_accept;

    assign w_ea     = req_base + req_imm;
    assign w_ea_ext = {1'b0, w_ea};
    assign w_last   = w_ea_ext + (XLEN+1)'(w_span);
    assign w_oor    = (w_ea_ext < c_lo) || (w_last >= c_hi);
    assign w_accept = (r_state == S_IDLE) && req_valid && !flush;

    // Decode access width (as size-1) and mode legality; unsigned modes are load-only.
    always_comb begin
        w_mode_ok = 1'b1;
        w_span    = 2'd0;
        case (req_mode)
            c_mode_b:  w_span = 2'd0;
            c_mode_h:  w_span = 2'd1;
            c_mode_w:  w_span = 2'd3;
            c_mode_bu: begin
                w_span    = 2'd0;
                w_mode_ok = req_load;
            end
            c_mode_hu: begin
                w_span    = 2'd1;
                w_mode_ok = req_load;
            end
            default:   w_mode_ok = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Natural alignment: halfwords on even addresses, words on multiples of four.
    always_comb begin
        w_misalign = 1'b0;
        if (w_span == 2'd1) begin
            w_misalign = w_ea[0];
        end else if (w_span == 2'd3) begin
            w_misalign = |w_ea[1:0];
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Prioritised fault classification: mode, then alignment, then range.
    always_comb begin
        w_fault = 1'b1;
        w_cause = c_cause_oor;
        if (!w_mode_ok) begin
            w_cause = c_cause_mode;
        end else if (w_misalign) begin
            w_cause = req_load ? c_cause_mald : c_cause_mast;
        end else if (w_oor) begin
            w_cause = c_cause_oor;
        end else begin
            w_fault = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the accepted op and its classification.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ea    <= '0;
            r_wdata <= '0;
            r_mode  <= '0;
            r_rd    <= '0;
            r_load  <= 1'b0;
            r_cause <= '0;
        end else if (w_accept) begin
            r_ea    <= w_ea;
            r_wdata <= req_wdata;
            r_mode  <= req_mode;
            r_rd    <= req_rd;
            r_load  <= req_load;
            r_cause <= w_cause;
        end
    end

    // Next state and outputs; flush kills pulses, rst forces every output low.
    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        dc_addr     = '0;
        dc_wdata    = '0;
        dc_mode     = '0;
        dc_write_en = 1'b0;
        dc_read_en  = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        st_done     = 1'b0;
        exc_valid   = 1'b0;
        exc_cause   = '0;
        exc_addr    = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_fault ? S_FAULT : S_ACC;
                end
            end
            S_ACC: begin
                dc_addr  = r_ea;
                dc_wdata = r_wdata;
                dc_mode  = r_mode;
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    dc_read_en  = r_load;
                    dc_write_en = !r_load;
                    st_done     = !r_load;
                    w_next      = r_load ? S_RESP : S_IDLE;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
                if (!flush) begin
                    wb_valid = 1'b1;
                    wb_rd    = r_rd;
                    wb_data  = dc_rdata;
                end
            end
            S_FAULT: begin
                w_next = S_IDLE;
                if (!flush) begin
                    exc_valid = 1'b1;
                    exc_cause = r_cause;
                    exc_addr  = r_ea;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            req_ready   = 1'b0;
            dc_addr     = '0;
            dc_wdata    = '0;
            dc_mode     = '0;
            dc_write_en = 1'b0;
            dc_read_en  = 1'b0;
            wb_valid    = 1'b0;
            wb_rd       = '0;
            wb_data     = '0;
            st_done     = 1'b0;
            exc_valid   = 1'b0;
            exc_cause   = '0;
            exc_addr    = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem
// Purpose  : Self-checking bench for lsu_mem: directed scenarios with
//            literal expectations plus randomized traffic compared every
//            cycle against a transaction-level model.
//            Honours MISALIGN_TRAP_EN when the design is built with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem;

    localparam logic [31:0] BASE = 32'h10000;
    localparam int          SIZE = 1024;
    localparam logic [2:0]  M_B  = 3'b000;
    localparam logic [2:0]  M_H  = 3'b001;
    localparam logic [2:0]  M_W  = 3'b010;
    localparam logic [2:0]  M_BU = 3'b100;
    localparam logic [2:0]  M_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_load, flush;
    logic [2:0]  req_mode, dc_mode;
    logic [31:0] req_base, req_imm, req_wdata;
    logic [4:0]  req_rd, wb_rd;
    logic [31:0] dc_addr, dc_wdata, dc_rdata, wb_data, exc_addr;
    logic        dc_write_en, dc_read_en, wb_valid, st_done, exc_valid;
    logic [1:0]  exc_cause;

    always #5 clk = ~clk;

    lsu_mem #(.XLEN(32), .DMEM_BASE(32'h10000), .DMEM_SIZE(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_mode(req_mode), .req_base(req_base), .req_imm(req_imm),
        .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_mode(dc_mode),
        .dc_write_en(dc_write_en), .dc_read_en(dc_read_en), .dc_rdata(dc_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .st_done(st_done),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: one outstanding op, tracked by its age in
    // cycles since acceptance.
    // ------------------------------------------------------------------
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_load, m_fault;
    logic [2:0]  m_mode;
    logic [31:0] m_ea, m_wdata;
    logic [4:0]  m_rd;
    logic [1:0]  m_cause;

    function automatic void classify(input bit ld, input logic [2:0] md, input logic [31:0] ea,
                                     output bit flt, output logic [1:0] cause);
        int size;
        bit legal;
        longint unsigned e;
        e     = ea;
        legal = 1'b1;
        size  = 1;
        case (md)
            M_B:     size = 1;
            M_H:     size = 2;
            M_W:     size = 4;
            M_BU:    begin size = 1; legal = ld; end
            M_HU:    begin size = 2; legal = ld; end
            default: legal = 1'b0;
        endcase
        flt   = 1'b1;
        cause = 2'b11;
        if (!legal) cause = 2'b00;
`ifdef MISALIGN_TRAP_EN
        else if ((e % longint'(size)) != 0) cause = ld ? 2'b01 : 2'b10;
`endif
        else if (e < longint'(BASE) || e + longint'(size) - 1 >= longint'(BASE) + SIZE) cause = 2'b11;
        else flt = 1'b0;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    initial begin
        logic        e_ready, e_rd_en, e_wr_en, e_st, e_wbv, e_exc, chk_addr;
        logic [31:0] e_addr, e_wdata, e_wbd, e_eaddr;
        logic [2:0]  e_mode;
        logic [4:0]  e_wbrd;
        logic [1:0]  e_cause;
        bit          f;
        logic [1:0]  c;
        forever begin
            @(negedge clk);
            #2;
            e_ready = 0; e_rd_en = 0; e_wr_en = 0; e_st = 0; e_wbv = 0; e_exc = 0;
            e_addr = 0; e_wdata = 0; e_mode = 0; e_wbd = 0; e_eaddr = 0; e_wbrd = 0;
            e_cause = 0; chk_addr = 1;
            if (!rst) begin
                e_ready = !m_busy;
                if (m_busy && m_age == 1) begin
                    if (m_fault) begin
                        if (!flush) begin
                            e_exc = 1; e_cause = m_cause; e_eaddr = m_ea;
                        end
                    end else if (flush) begin
                        chk_addr = 0;
                    end else begin
                        e_addr = m_ea; e_mode = m_mode; e_wdata = m_wdata;
                        e_rd_en = m_load; e_wr_en = !m_load; e_st = !m_load;
                    end
                end
                if (m_busy && m_age == 2 && !flush) begin
                    e_wbv = 1; e_wbrd = m_rd; e_wbd = dc_rdata;
                end
            end
            cmp("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
            cmp("dc_read_en", {31'b0, dc_read_en}, {31'b0, e_rd_en});
            cmp("dc_write_en", {31'b0, dc_write_en}, {31'b0, e_wr_en});
            cmp("st_done", {31'b0, st_done}, {31'b0, e_st});
            cmp("wb_valid", {31'b0, wb_valid}, {31'b0, e_wbv});
            cmp("wb_rd", {27'b0, wb_rd}, {27'b0, e_wbrd});
            cmp("wb_data", wb_data, e_wbd);
            cmp("exc_valid", {31'b0, exc_valid}, {31'b0, e_exc});
            cmp("exc_cause", {30'b0, exc_cause}, {30'b0, e_cause});
            cmp("exc_addr", exc_addr, e_eaddr);
            if (chk_addr) begin
                cmp("dc_addr", dc_addr, e_addr);
                cmp("dc_mode", {29'b0, dc_mode}, {29'b0, e_mode});
                cmp("dc_wdata", dc_wdata, e_wdata);
            end
            // inputs are stable through the coming rising edge
            if (rst) begin
                m_busy = 0;
            end else if (m_busy) begin
                if (m_age == 1 && !m_fault && m_load && !flush) m_age = 2;
                else m_busy = 0;
            end else if (req_valid && !flush) begin
                m_busy = 1; m_age = 1;
                m_load = req_load; m_mode = req_mode; m_ea = req_base + req_imm;
                m_wdata = req_wdata; m_rd = req_rd;
                classify(req_load, req_mode, req_base + req_imm, f, c);
                m_fault = f; m_cause = c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        rst = 0; req_valid = 0; flush = 0; dc_rdata = 0;
    endtask

    task automatic issue(input bit ld, input logic [2:0] md, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] wd, input logic [4:0] rd);
        step();
        req_valid = 1; req_load = ld; req_mode = md; req_base = b; req_imm = i;
        req_wdata = wd; req_rd = rd;
    endtask

    initial begin
        logic [1:0] sw_cause;
`ifdef MISALIGN_TRAP_EN
        sw_cause = 2'b10;
`else
        sw_cause = 2'b11;
`endif
        rst = 1; req_valid = 0; req_load = 0; req_mode = 0; req_base = 0; req_imm = 0;
        req_wdata = 0; req_rd = 0; flush = 0; dc_rdata = 0;
        repeat (3) @(negedge clk);
        #3;
        cmp("rst_ready", {31'b0, req_ready}, 32'd0);
        cmp("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        step();
        #3 cmp("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // LW 0x10000+8
        issue(1, M_W, 32'h10000, 32'd8, 32'h0, 5'd7);
        step();
        #3;
        cmp("lw_read_en", {31'b0, dc_read_en}, 32'd1);
        cmp("lw_addr", dc_addr, 32'h10008);
        cmp("lw_mode", {29'b0, dc_mode}, {29'b0, M_W});
        step(); dc_rdata = 32'hDEADBEEF;
        #3;
        cmp("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
        cmp("lw_wb_data", wb_data, 32'hDEADBEEF);
        cmp("lw_wb_rd", {27'b0, wb_rd}, 32'd7);

        // SB at the last byte of memory
        issue(0, M_B, 32'h10000, 32'h3FF, 32'hA5, 5'd0);
        step();
        #3;
        cmp("sb_write_en", {31'b0, dc_write_en}, 32'd1);
        cmp("sb_addr", dc_addr, 32'h103FF);
        cmp("sb_wdata", dc_wdata, 32'hA5);
        cmp("sb_st_done", {31'b0, st_done}, 32'd1);
        step();
        #3;
        cmp("sb_write_en_once", {31'b0, dc_write_en}, 32'd0);
        cmp("sb_no_wb", {31'b0, wb_valid}, 32'd0);

        // SW straddling the end of memory
        issue(0, M_W, 32'h10000, 32'h3FE, 32'h1, 5'd0);
        step();
        #3;
        cmp("sw_exc_valid", {31'b0, exc_valid}, 32'd1);
        cmp("sw_exc_cause", {30'b0, exc_cause}, {30'b0, sw_cause});
        cmp("sw_exc_addr", exc_addr, 32'h103FE);
        cmp("sw_no_strobe", {31'b0, dc_write_en | dc_read_en}, 32'd0);

        // LW below memory
        issue(1, M_W, 32'h0FFFC, 32'd0, 32'h0, 5'd3);
        step();
        #3;
        cmp("lw_low_exc", {31'b0, exc_valid}, 32'd1);
        cmp("lw_low_cause", {30'b0, exc_cause}, 32'd3);
        step();
        #3 cmp("lw_low_no_wb", {31'b0, wb_valid}, 32'd0);

        // LW flushed in RESP
        issue(1, M_W, 32'h10000, 32'h10, 32'h0, 5'd9);
        step();
        step(); flush = 1; dc_rdata = 32'h12345678;
        #3 cmp("flush_resp_no_wb", {31'b0, wb_valid}, 32'd0);
        step();
        #3 cmp("flush_resp_ready", {31'b0, req_ready}, 32'd1);

        // SW hit by reset in ACC
        issue(0, M_W, 32'h10000, 32'h20, 32'h1234, 5'd0);
        step(); rst = 1;
        #3;
        cmp("rst_acc_write_en", {31'b0, dc_write_en}, 32'd0);
        cmp("rst_acc_st_done", {31'b0, st_done}, 32'd0);
        cmp("rst_acc_addr", dc_addr, 32'd0);
        cmp("rst_acc_ready", {31'b0, req_ready}, 32'd0);
        step();
        #3 cmp("rst_acc_ready_after", {31'b0, req_ready}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 8);
            req_valid = ($urandom_range(0, 99) < 70);
            req_load  = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       req_mode = M_B;
                1:       req_mode = M_H;
                2:       req_mode = M_W;
                3:       req_mode = M_BU;
                4:       req_mode = M_HU;
                default: req_mode = 3'($urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 19) == 0) req_base = $urandom;
            else req_base = BASE + $urandom_range(0, SIZE + 32) - 32'd16;
            req_imm   = $urandom_range(0, 15) - 32'd8;
            req_wdata = $urandom;
            req_rd    = 5'($urandom_range(0, 31));
            dc_rdata  = $urandom;
        end

        step();
        step();
        step();
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter DMEM_BASE, default 32'h10000, byte address of data-memory byte 0.
REQ-003 SHALL have parameter DMEM_SIZE, default 1024, data-memory size in bytes.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  EX stage presents a memory op.
REQ-007 SHALL have port req_ready  out  1  LSU can accept an op this cycle.
REQ-008 SHALL have port req_load  in  1  1 = load, 0 = store.
REQ-009 SHALL have port req_mode  in  3  `MEM_MODE_B/H/W/BU/HU encoding from defines.v.
REQ-010 SHALL have port req_base  in  XLEN  rs1 value.
REQ-011 SHALL have port req_imm  in  XLEN  sign-extended offset.
REQ-012 SHALL have port req_wdata  in  XLEN  store data (rs2).
REQ-013 SHALL have port req_rd  in  5  load destination register.
REQ-014 SHALL have port flush  in  1  pipeline kill.
REQ-015 SHALL have ports dc_addr (out, XLEN), dc_wdata (out, XLEN), dc_mode (out, 3): address, write data and mode to data cache.
REQ-016 SHALL have ports dc_write_en (out, 1) and dc_read_en (out, 1): data-cache strobes.
REQ-017 SHALL have port dc_rdata  in  XLEN  extended load data returned by the data cache.
REQ-018 SHALL have ports wb_valid (out, 1), wb_rd (out, 5), wb_data (out, XLEN): load writeback.
REQ-019 SHALL have port st_done  out  1  one-cycle pulse when a store completes.
REQ-020 SHALL have ports exc_valid (out, 1), exc_cause (out, 2), exc_addr (out, XLEN): exception report; cause 00 = illegal mode, 01 = misaligned load, 10 = misaligned store, 11 = out of range.

Function
REQ-021 SHALL implement FSM states IDLE, ACC, RESP, FAULT; req_ready SHALL be 1 only in IDLE with rst=0.
REQ-022 SHALL accept an op in IDLE when req_valid=1 and flush=0, registering ea = req_base+req_imm (mod 2^XLEN) and all req_* fields.
REQ-023 SHALL classify the op at acceptance. A check fails and the FSM goes to FAULT if:
- mode is not one of B/H/W/BU/HU, or is BU/HU with req_load=0, giving cause 00;
- alignment fails (REQ-033);
- ea<DMEM_BASE or ea+size-1 >= DMEM_BASE+DMEM_SIZE, giving cause 11.
Otherwise the FSM SHALL go to ACC.
REQ-024 SHALL, when more than one check fails, report the highest-priority cause, in order: 00, then 01/10, then 11.
REQ-025 SHALL, in ACC, drive dc_addr=ea, dc_mode and dc_wdata for exactly one cycle, with dc_read_en=req_load and dc_write_en=!req_load; dc_read_en and dc_write_en SHALL never both be 1.
REQ-026 SHALL, in ACC, transition a store to IDLE and pulse st_done, and transition a load to RESP.
REQ-027 SHALL, in RESP, capture dc_rdata into wb_data and pulse wb_valid with wb_rd for one cycle, then return to IDLE.
REQ-028 SHALL, in FAULT, pulse exc_valid for one cycle with exc_cause and exc_addr=ea, assert no dc strobe, then return to IDLE.
REQ-029 SHALL give load latency: accept at cycle N, dc_read_en at N+1, wb_valid at N+2. Store latency: dc_write_en and st_done at N+1. Throughput SHALL be one op per 2 cycles (store) or 3 cycles (load).
REQ-030 SHALL handle flush as follows:
- flush in IDLE blocks acceptance;
- flush in ACC suppresses both strobes and st_done, and the FSM returns to IDLE;
- flush in RESP or FAULT suppresses wb_valid or exc_valid, and the FSM returns to IDLE.
REQ-031 SHALL hold dc_* outputs at 0 in every state except ACC.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, enter IDLE, clear all registered fields, and drive every output to 0 (req_ready=0, dc_*=0, wb_*=0, st_done=0, exc_*=0). rst SHALL override any op in flight, including a strobe due in ACC; req_ready SHALL become 1 on the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, when macro MISALIGN_TRAP_EN is defined, fail alignment for H/HU with ea[0]!=0 and for W with ea[1:0]!=0, giving cause 01 for loads and 10 for stores; when it is undefined, SHALL skip the alignment check, so cause 01/10 is never produced and the access proceeds at the unaligned ea.

Verification
REQ-034 SHALL cover: LW with base=0x10000, imm=8, dc_rdata=0xDEADBEEF -> dc_read_en at N+1 with dc_addr=0x10008 and dc_mode=W; wb_valid at N+2 with wb_data=0xDEADBEEF.
REQ-035 SHALL cover: SB with base=0x10000, imm=0x3FF, wdata=0xA5 -> dc_write_en for exactly one cycle at N+1 with dc_addr=0x103FF; st_done at N+1; no wb_valid.
REQ-036 SHALL cover: SW with base=0x10000, imm=0x3FE -> with MISALIGN_TRAP_EN: exc_valid, cause 10, exc_addr=0x103FE; without it: exc_valid, cause 11; no dc strobe in either case.
REQ-037 SHALL cover: LW at ea=0x0FFFC -> exc_valid with cause 11 at N+1; wb_valid never asserts.
REQ-038 SHALL cover: LW accepted, then flush=1 in RESP -> no wb_valid; req_ready=1 on the next cycle.
REQ-039 SHALL cover: SW accepted, then rst=1 in ACC -> dc_write_en=0 that cycle; all outputs 0; req_ready=1 one cycle after rst deasserts.
